// File: rtl/multi_queue_transceiver.sv
// multi_queue_transceiver: NoC switch output stage. Drains several input queues in
// round-robin order onto independent r/w-handshake output ports, with an ack timeout.

module routing_module #(
    parameter int ADDR      = 0,
    parameter int ADDR_SIZE = 4,
    parameter int PORTS_NUM = 4,
    parameter int NODES_NUM = 9,
    parameter int PW        = 3
) (
    input  logic [ADDR_SIZE-1:0] dest_sw,
    output logic [PW-1:0]        port
);
    // Nodes sit on a square mesh; XY routing: ports 0/1 = +x/-x, 2/3 = +y/-y, PORTS_NUM = self.
    function automatic int mesh_width(input int nodes);
        int w;
        w = 1;
        while (w * w < nodes) w++;
        return w;
    endfunction

    localparam int MESH_W = mesh_width(NODES_NUM);
    localparam int SELF_X = ADDR % MESH_W;
    localparam int SELF_Y = ADDR / MESH_W;

    int dest_x;
    int dest_y;

    always_comb begin
        dest_x = int'(dest_sw) % MESH_W;
        dest_y = int'(dest_sw) / MESH_W;
        port   = PW'(PORTS_NUM);
        if (dest_x > SELF_X)      port = PW'(0);
        else if (dest_x < SELF_X) port = PW'(1);
        else if (dest_y > SELF_Y) port = PW'(2);
        else if (dest_y < SELF_Y) port = PW'(3);
    end
endmodule

module multi_queue_transceiver #(
    parameter int                 ADDR       = 0,
    parameter int                 DATA_SIZE  = 32,
    parameter int                 ADDR_SIZE  = 4,
    parameter int                 PORTS_NUM  = 4,
    parameter int                 NODES_NUM  = 9,
    parameter int                 QUEUES_NUM = 5,
    parameter logic [PORTS_NUM:0] PORT_MASK  = {(PORTS_NUM + 1){1'b1}},
    parameter int                 TIMEOUT    = 16,
    localparam int                BUS_SIZE   = DATA_SIZE + ADDR_SIZE + 1
) (
    input  logic                                clk,
    input  logic                                a_rst,
    input  logic [QUEUES_NUM-1:0]               mem_empty,
    input  logic [BUS_SIZE*QUEUES_NUM-1:0]      data_i,
    input  logic [PORTS_NUM:0]                  out_w,
    output logic [QUEUES_NUM-1:0]               readed,
    output logic [PORTS_NUM:0]                  out_r,
    output logic [BUS_SIZE*(PORTS_NUM+1)-1:0]   data_o,
    output logic [7:0]                          drop_cnt,
    output logic [PORTS_NUM:0]                  port_busy
);
    localparam int NP = PORTS_NUM + 1;
    localparam int PW = (NP > 1) ? $clog2(NP) : 1;
    localparam int QW = (QUEUES_NUM > 1) ? $clog2(QUEUES_NUM) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [PW-1:0]         raw_port [QUEUES_NUM];
    logic [PW-1:0]         port_sel [QUEUES_NUM];
    logic [QUEUES_NUM-1:0] elig;
    logic [QW-1:0]         rr;
    logic [QW-1:0]         gnt_q;
    logic                  gnt_vld;
    logic [PW-1:0]         gnt_port;
    logic [TW-1:0]         to_cnt [NP];
    logic [NP-1:0]         ack;
    logic [NP-1:0]         expire;

    function automatic logic [7:0] sat_add(input logic [7:0] cnt, input int inc);
        int sum;
        sum = int'(cnt) + inc;
        return (sum > 255) ? 8'hFF : 8'(sum);
    endfunction

    // A port holds an outstanding flit exactly while its valid is raised.
    assign port_busy = out_r;

    genvar q;
    generate
        for (q = 0; q < QUEUES_NUM; q++) begin : g_route
            routing_module #(
                .ADDR      (ADDR),
                .ADDR_SIZE (ADDR_SIZE),
                .PORTS_NUM (PORTS_NUM),
                .NODES_NUM (NODES_NUM),
                .PW        (PW)
            ) u_route (
                .dest_sw (data_i[q*BUS_SIZE +: ADDR_SIZE]),
                .port    (raw_port[q])
            );
            assign port_sel[q] = PORT_MASK[raw_port[q]] ? raw_port[q] : PW'(PORTS_NUM);
            assign elig[q]     = !mem_empty[q] && !readed[q] && !port_busy[port_sel[q]];
        end
    endgenerate

    // Round-robin search starts just past the last winner.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_q   = '0;
        for (int i = 1; i <= QUEUES_NUM; i++) begin
            if (!gnt_vld && elig[(int'(rr) + i) % QUEUES_NUM]) begin
                gnt_vld = 1'b1;
                gnt_q   = QW'((int'(rr) + i) % QUEUES_NUM);
            end
        end
    end

    assign gnt_port = port_sel[gnt_q];

    // An ack on the expiry edge wins over the drop.
    always_comb begin
        ack    = '0;
        expire = '0;
        for (int p = 0; p < NP; p++) begin
            ack[p]    = out_r[p] && out_w[p];
            expire[p] = out_r[p] && !out_w[p] && (TIMEOUT > 0) && (to_cnt[p] == TW'(TIMEOUT - 1));
        end
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            readed   <= '0;
            out_r    <= '0;
            data_o   <= '0;
            drop_cnt <= '0;
            rr       <= QW'(QUEUES_NUM - 1);
            for (int p = 0; p < NP; p++) to_cnt[p] <= '0;
        end else begin
            readed   <= '0;
            drop_cnt <= sat_add(drop_cnt, $countones(expire));
            for (int p = 0; p < NP; p++) begin
                if (ack[p] || expire[p]) begin
                    out_r[p]  <= 1'b0;
                    to_cnt[p] <= '0;
                end else if (out_r[p] && (TIMEOUT > 0)) begin
                    to_cnt[p] <= to_cnt[p] + TW'(1);
                end
            end
            // Granted port is idle here, so this never collides with the handshake above.
            if (gnt_vld) begin
                data_o[int'(gnt_port)*BUS_SIZE +: BUS_SIZE] <= data_i[int'(gnt_q)*BUS_SIZE +: BUS_SIZE];
                out_r[gnt_port]  <= 1'b1;
                to_cnt[gnt_port] <= '0;
                readed[gnt_q]    <= 1'b1;
                rr               <= gnt_q;
            end
        end
    end
endmodule

// File: tb/tb_multi_queue_transceiver.sv
// Scoreboard bench for multi_queue_transceiver: queue-level reference model predicts
// grants, port occupancy and drops; a monitor compares DUT outputs after each edge.
`timescale 1ns/1ps

module tb_multi_queue_transceiver;
    localparam int ADDR       = 4;
    localparam int DATA_SIZE  = 32;
    localparam int ADDR_SIZE  = 4;
    localparam int PORTS_NUM  = 4;
    localparam int NODES_NUM  = 9;
    localparam int QUEUES_NUM = 5;
    localparam int TIMEOUT    = 16;
    localparam logic [PORTS_NUM:0] PORT_MASK = 5'b10111;
    localparam int BUS_SIZE   = DATA_SIZE + ADDR_SIZE + 1;
    localparam int NP         = PORTS_NUM + 1;
    localparam int MESH       = 3;

    typedef logic [BUS_SIZE-1:0] flit_t;
    typedef struct packed {
        logic [NP-1:0]         vld;
        logic [QUEUES_NUM-1:0] rd;
        logic [7:0]            drops;
    } ctrl_t;
    typedef enum {ACK_ALL, ACK_NONE, ACK_AT16, ACK_RAND} ack_mode_t;

    logic                         clk = 1'b0;
    logic                         a_rst = 1'b1;
    logic [QUEUES_NUM-1:0]        mem_empty;
    logic [BUS_SIZE*QUEUES_NUM-1:0] data_i;
    logic [NP-1:0]                out_w;
    logic [QUEUES_NUM-1:0]        readed;
    logic [NP-1:0]                out_r;
    logic [BUS_SIZE*NP-1:0]       data_o;
    logic [7:0]                   drop_cnt;
    logic [NP-1:0]                port_busy;

    multi_queue_transceiver #(
        .ADDR(ADDR), .DATA_SIZE(DATA_SIZE), .ADDR_SIZE(ADDR_SIZE), .PORTS_NUM(PORTS_NUM),
        .NODES_NUM(NODES_NUM), .QUEUES_NUM(QUEUES_NUM), .PORT_MASK(PORT_MASK), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .a_rst(a_rst), .mem_empty(mem_empty), .data_i(data_i), .out_w(out_w),
        .readed(readed), .out_r(out_r), .data_o(data_o), .drop_cnt(drop_cnt), .port_busy(port_busy)
    );

    always #5 clk = ~clk;

    int        n_cmp = 0;
    int        n_fail = 0;
    flit_t     fifo [QUEUES_NUM][$];
    flit_t     exp_flit [NP][$];
    ctrl_t     exp_ctrl [$];
    int        m_rr;
    bit        m_busy [NP];
    int        m_cnt [NP];
    int        m_blocked;
    int        m_drop;
    int        pend_pop;
    ack_mode_t ack_mode;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Mesh XY routing from coordinates, then disconnected ports fall back to local.
    function automatic int route(input flit_t f);
        logic [NP-1:0] mask;
        int d, p;
        mask = PORT_MASK;
        d = int'(f[ADDR_SIZE-1:0]);
        if (d % MESH > ADDR % MESH)      p = 0;
        else if (d % MESH < ADDR % MESH) p = 1;
        else if (d / MESH > ADDR / MESH) p = 2;
        else if (d / MESH < ADDR / MESH) p = 3;
        else                             p = PORTS_NUM;
        if (!mask[p]) p = PORTS_NUM;
        return p;
    endfunction

    function automatic flit_t mk(input int dest, input logic [31:0] payload);
        return {1'($urandom_range(1)), payload, ADDR_SIZE'(dest)};
    endfunction

    task automatic push(input int q, input flit_t f);
        fifo[q].push_back(f);
    endtask

    task automatic model_reset();
        m_rr = QUEUES_NUM - 1;
        m_blocked = -1;
        m_drop = 0;
        pend_pop = -1;
        for (int p = 0; p < NP; p++) begin
            m_busy[p] = 1'b0;
            m_cnt[p] = 0;
            exp_flit[p].delete();
        end
        for (int q = 0; q < QUEUES_NUM; q++) fifo[q].delete();
    endtask

    // One clock: drive queue heads and acks, then predict what the next edge produces.
    task automatic cycle();
        logic [NP-1:0] ack;
        bit            busy_pre [NP];
        int            g;
        ctrl_t         c;
        @(negedge clk);
        if (pend_pop >= 0) begin
            fifo[pend_pop].delete(0);
            pend_pop = -1;
        end
        for (int q = 0; q < QUEUES_NUM; q++) begin
            mem_empty[q] = (fifo[q].size() == 0);
            data_i[q*BUS_SIZE +: BUS_SIZE] = (fifo[q].size() > 0) ? fifo[q][0] : '0;
        end
        for (int p = 0; p < NP; p++) begin
            case (ack_mode)
                ACK_ALL:  ack[p] = 1'b1;
                ACK_NONE: ack[p] = 1'b0;
                ACK_AT16: ack[p] = m_busy[p] && (m_cnt[p] == TIMEOUT - 1);
                default:  ack[p] = ($urandom_range(3) == 0);
            endcase
        end
        out_w = ack;
        busy_pre = m_busy;
        for (int p = 0; p < NP; p++) begin
            if (m_busy[p]) begin
                if (ack[p]) begin
                    m_busy[p] = 1'b0;
                    m_cnt[p] = 0;
                end else if (m_cnt[p] == TIMEOUT - 1) begin
                    m_busy[p] = 1'b0;
                    m_cnt[p] = 0;
                    if (m_drop < 255) m_drop++;
                end else begin
                    m_cnt[p]++;
                end
            end
        end
        g = -1;
        for (int i = 1; i <= QUEUES_NUM && g < 0; i++) begin
            int q;
            q = (m_rr + i) % QUEUES_NUM;
            if (fifo[q].size() > 0 && q != m_blocked && !busy_pre[route(fifo[q][0])]) g = q;
        end
        m_blocked = g;
        c.rd = '0;
        if (g >= 0) begin
            int p;
            p = route(fifo[g][0]);
            m_busy[p] = 1'b1;
            m_cnt[p] = 0;
            exp_flit[p].push_back(fifo[g][0]);
            m_rr = g;
            pend_pop = g;
            c.rd[g] = 1'b1;
        end
        for (int p = 0; p < NP; p++) c.vld[p] = m_busy[p];
        c.drops = 8'(m_drop);
        exp_ctrl.push_back(c);
    endtask

    task automatic drain(input string name, input int limit);
        int  n;
        bit  pending;
        n = 0;
        do begin
            pending = (pend_pop >= 0);
            for (int q = 0; q < QUEUES_NUM; q++) if (fifo[q].size() > 0) pending = 1'b1;
            for (int p = 0; p < NP; p++) if (m_busy[p]) pending = 1'b1;
            if (pending) begin
                cycle();
                n++;
            end
        end while (pending && n < limit);
        chk(name, n < limit, 1'b1);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_out_r"}, out_r, '0);
        chk({tag, "_port_busy"}, port_busy, '0);
        chk({tag, "_readed"}, readed, '0);
        chk({tag, "_drop_cnt"}, drop_cnt, '0);
        chk({tag, "_data_o"}, data_o == '0, 1'b1);
    endtask

    // Monitor: one control expectation per modelled edge; each new valid pops a flit.
    initial begin : monitor
        logic [NP-1:0] prev_r;
        flit_t         cur [NP];
        flit_t         got;
        ctrl_t         c;
        prev_r = '0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_ctrl.size() > 0) begin
                c = exp_ctrl.pop_front();
                chk("out_r", out_r, c.vld);
                chk("port_busy", port_busy, c.vld);
                chk("readed", readed, c.rd);
                chk("drop_cnt", drop_cnt, c.drops);
            end
            for (int p = 0; p < NP; p++) begin
                got = data_o[p*BUS_SIZE +: BUS_SIZE];
                if (out_r[p] && !prev_r[p]) begin
                    chk($sformatf("flit_expected_p%0d", p), exp_flit[p].size() != 0, 1'b1);
                    if (exp_flit[p].size() != 0) begin
                        cur[p] = exp_flit[p].pop_front();
                        chk($sformatf("flit_data_p%0d", p), got, cur[p]);
                    end
                end else if (out_r[p]) begin
                    chk($sformatf("data_stable_p%0d", p), got, cur[p]);
                end
            end
            prev_r = out_r;
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: bench did not finish, required completion before 2ms");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1);
    end

    initial begin : stimulus
        mem_empty = '1;
        data_i = '0;
        out_w = '0;
        ack_mode = ACK_ALL;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_cleared("reset");
        @(negedge clk);
        a_rst = 1'b0;

        repeat (20) cycle();

        push(0, mk(ADDR, 32'hDEADBEEF));
        repeat (4) cycle();

        push(0, mk(4, 32'h0000_0A00));
        push(1, mk(4, 32'h0000_0A01));
        push(2, mk(4, 32'h0000_0A02));
        repeat (2) cycle();
        push(0, mk(4, 32'h0000_0B00));
        push(1, mk(4, 32'h0000_0B01));
        repeat (12) cycle();

        ack_mode = ACK_NONE;
        push(1, mk(5, 32'h1111_0001));
        push(3, mk(7, 32'h3333_0003));
        repeat (8) cycle();
        ack_mode = ACK_ALL;
        repeat (3) cycle();

        push(2, mk(1, 32'h5555_AAAA));
        repeat (4) cycle();

        ack_mode = ACK_NONE;
        push(0, mk(5, 32'h7100_0001));
        repeat (20) cycle();
        chk("drop_after_timeout", drop_cnt, 8'd1);

        ack_mode = ACK_AT16;
        push(0, mk(7, 32'h7100_0002));
        repeat (20) cycle();
        chk("drop_after_late_ack", drop_cnt, 8'd1);

        ack_mode = ACK_RAND;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(2) == 0) begin
                int q;
                q = $urandom_range(QUEUES_NUM - 1);
                if (fifo[q].size() < 4) push(q, mk($urandom_range(NODES_NUM - 1), $urandom));
            end
            cycle();
        end
        ack_mode = ACK_ALL;
        drain("random_drain", 500);

        ack_mode = ACK_NONE;
        for (int n = 0; n < 300; n++) push(n % QUEUES_NUM, mk($urandom_range(NODES_NUM - 1), $urandom));
        drain("saturation_drain", 9000);
        chk("drop_saturated", drop_cnt, 8'd255);

        push(1, mk(3, 32'hCAFE_F00D));
        repeat (3) cycle();
        chk("busy_before_reset", out_r != '0, 1'b1);
        @(posedge clk);
        #3;
        a_rst = 1'b1;
        #1;
        chk_cleared("async_reset");
        model_reset();
        mem_empty = '1;
        @(negedge clk);
        a_rst = 1'b0;
        repeat (5) cycle();
        @(posedge clk);
        #2;
        chk("scoreboard_empty", exp_ctrl.size() + exp_flit[0].size() + exp_flit[1].size()
            + exp_flit[2].size() + exp_flit[3].size() + exp_flit[4].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
